// File: rtl/qed_consistency_monitor.sv
// qed_consistency_monitor
// Watches the original and duplicate instruction streams of an SQED-style
// split core. When the two commit counts meet (equal, non-zero, not
// saturated), it snapshots the split register file and scans each
// original/duplicate register pair over NUM_REGS/LANES cycles.
//
// Ports
//   clk           core clock
//   rst           asynchronous active-low reset
//   chk_en        enables triggering of new checks
//   clr_err       synchronous clear of sticky flags and mismatch_idx
//   orig_commit   one original instruction committed this cycle
//   dup_commit    one duplicate instruction committed this cycle
//   regs_flat     split regfile, reg i at [i*XLEN +: XLEN]; dup of i is i+NUM_REGS
//   busy          scan or done phase in progress
//   check_done    one-cycle pulse at the end of each check
//   check_pass    valid with check_done: every compared pair was equal
//   mismatch      sticky: some check failed
//   mismatch_idx  lowest failing pair of the first failing check
//   seq_err       sticky: dup count overtook orig count, or a counter saturated
//   overlap_err   sticky: a trigger arrived while busy and was dropped
//   check_count   completed checks, saturating
module qed_consistency_monitor #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned SKIP_REG0 = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         chk_en,
  input  logic                         clr_err,
  input  logic                         orig_commit,
  input  logic                         dup_commit,
  input  logic [2*NUM_REGS*XLEN-1:0]   regs_flat,
  output logic                         busy,
  output logic                         check_done,
  output logic                         check_pass,
  output logic                         mismatch,
  output logic [$clog2(NUM_REGS)-1:0]  mismatch_idx,
  output logic                         seq_err,
  output logic                         overlap_err,
  output logic [CNT_W-1:0]             check_count
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);
  localparam int unsigned LAST = NUM_REGS - LANES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             r_orig_cnt;
  logic [CNT_W-1:0]             r_dup_cnt;
  logic [CNT_W-1:0]             w_orig_nxt;
  logic [CNT_W-1:0]             w_dup_nxt;
  logic                         r_ready_q;
  logic                         r_ready_d;
  logic [2*NUM_REGS*XLEN-1:0]   r_snap;
  logic [IDXW-1:0]              r_idx;
  logic                         r_fail;
  logic                         r_mismatch;
  logic [IDXW-1:0]              r_mismatch_idx;
  logic                         r_seq_err;
  logic                         r_overlap_err;
  logic [CNT_W-1:0]             r_check_count;

  logic                         w_orig_max;
  logic                         w_dup_max;
  logic                         w_ready;
  logic                         w_trig;
  logic                         w_seq_set;
  logic                         w_ovl_set;
  logic                         w_start;
  logic                         w_scan;
  logic                         w_done;
  logic                         w_latch;
  logic                         w_grp_fail;
  logic [IDXW-1:0]              w_grp_idx;

  // Commit counters, saturating at all-ones.
  assign w_orig_max = &r_orig_cnt;
  assign w_dup_max  = &r_dup_cnt;
  assign w_orig_nxt = (orig_commit && !w_orig_max) ? r_orig_cnt + CNT_W'(1) : r_orig_cnt;
  assign w_dup_nxt  = (dup_commit  && !w_dup_max)  ? r_dup_cnt  + CNT_W'(1) : r_dup_cnt;

  // Sequencing violations are judged only on cycles that carry a commit, so a
  // parked saturated counter does not keep re-asserting seq_err after clr_err.
  assign w_seq_set = (orig_commit || dup_commit) &&
                     ((&w_orig_nxt) || (&w_dup_nxt) || (w_dup_nxt > w_orig_nxt));

  assign w_ready = (r_orig_cnt == r_dup_cnt) && (r_orig_cnt != '0) &&
                   !w_orig_max && !w_dup_max;
  assign w_trig  = chk_en && r_ready_q && !r_ready_d;

  assign w_scan    = (r_state == S_SCAN);
  assign w_done    = (r_state == S_DONE);
  assign w_ovl_set = w_trig && (r_state != S_IDLE);
  // Only the first failing group of a check may record the index, and only
  // while no earlier check has failed.
  assign w_latch   = w_scan && w_grp_fail && !r_mismatch && !r_fail;

  // Compare the current group of pairs from the snapshot.
  always_comb begin
    int unsigned p;
    w_grp_fail = 1'b0;
    w_grp_idx  = '0;
    p          = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      p = 32'(r_idx) + l;
      if ((r_snap[p*XLEN +: XLEN] != r_snap[(p+NUM_REGS)*XLEN +: XLEN]) &&
          !((SKIP_REG0 != 0) && (p == 0)) && !w_grp_fail) begin
        w_grp_fail = 1'b1;
        w_grp_idx  = IDXW'(p);
      end
    end
  end

  // Next-state and phase outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    busy        = (r_state != S_IDLE);
    check_done  = (r_state == S_DONE);
    check_pass  = (r_state == S_DONE) && !r_fail;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_start     = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx == IDXW'(LAST)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_orig_cnt     <= '0;
      r_dup_cnt      <= '0;
      r_ready_q      <= 1'b0;
      r_ready_d      <= 1'b0;
      r_snap         <= '0;
      r_idx          <= '0;
      r_fail         <= 1'b0;
      r_mismatch     <= 1'b0;
      r_mismatch_idx <= '0;
      r_seq_err      <= 1'b0;
      r_overlap_err  <= 1'b0;
      r_check_count  <= '0;
    end else begin
      r_orig_cnt <= w_orig_nxt;
      r_dup_cnt  <= w_dup_nxt;
      r_ready_q  <= w_ready;
      r_ready_d  <= r_ready_q;

      if (w_start) begin
        r_snap <= regs_flat;
        r_idx  <= '0;
        r_fail <= 1'b0;
      end else if (w_scan) begin
        r_idx <= r_idx + IDXW'(LANES);
        if (w_grp_fail) r_fail <= 1'b1;
      end

      // Set events take priority over clr_err.
      r_seq_err     <= w_seq_set | (r_seq_err & ~clr_err);
      r_overlap_err <= w_ovl_set | (r_overlap_err & ~clr_err);
      r_mismatch    <= (w_done & r_fail) | (r_mismatch & ~clr_err);

      if (w_latch)      r_mismatch_idx <= w_grp_idx;
      else if (clr_err) r_mismatch_idx <= '0;

      if (w_done && !(&r_check_count)) r_check_count <= r_check_count + CNT_W'(1);
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_idx = r_mismatch_idx;
  assign seq_err      = r_seq_err;
  assign overlap_err  = r_overlap_err;
  assign check_count  = r_check_count;

endmodule

// File: tb/tb_qed_consistency_monitor.sv
// Testbench for qed_consistency_monitor: two instances (default parameters,
// and LANES=2 / SKIP_REG0=0 / CNT_W=4) share one stimulus stream and are
// compared every cycle against a transaction-level model, plus directed
// scenarios with literal expectations.
module tb_qed_consistency_monitor;

  localparam int NR = 16;
  localparam int XL = 32;

  logic clk;
  logic rst;
  logic chk_en;
  logic clr_err;
  logic orig_commit;
  logic dup_commit;
  logic [2*NR*XL-1:0] regs_flat;
  logic [XL-1:0] regs [2*NR];

  logic       a_busy, a_done, a_pass, a_mis, a_seq, a_ovl;
  logic [3:0] a_midx;
  logic [15:0] a_cnt;
  logic       b_busy, b_done, b_pass, b_mis, b_seq, b_ovl;
  logic [3:0] b_midx;
  logic [3:0] b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  qed_consistency_monitor #(
    .XLEN(XL), .NUM_REGS(NR), .LANES(4), .SKIP_REG0(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err),
    .orig_commit(orig_commit), .dup_commit(dup_commit), .regs_flat(regs_flat),
    .busy(a_busy), .check_done(a_done), .check_pass(a_pass), .mismatch(a_mis),
    .mismatch_idx(a_midx), .seq_err(a_seq), .overlap_err(a_ovl), .check_count(a_cnt)
  );

  qed_consistency_monitor #(
    .XLEN(XL), .NUM_REGS(NR), .LANES(2), .SKIP_REG0(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err),
    .orig_commit(orig_commit), .dup_commit(dup_commit), .regs_flat(regs_flat),
    .busy(b_busy), .check_done(b_done), .check_pass(b_pass), .mismatch(b_mis),
    .mismatch_idx(b_midx), .seq_err(b_seq), .overlap_err(b_ovl), .check_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 2*NR; i++) regs_flat[i*XL +: XL] = regs[i];
  end

  // ---------------- reference model ----------------
  function automatic int groups(input int d);  return d == 0 ? 4 : 8;      endfunction
  function automatic int lanes(input int d);   return d == 0 ? 4 : 2;      endfunction
  function automatic int skip0(input int d);   return d == 0 ? 1 : 0;      endfunction
  function automatic int cmax(input int d);    return d == 0 ? 65535 : 15; endfunction

  int m_orig [2];
  int m_dup  [2];
  int m_t    [2];   // 0 idle, 1..groups scanning group t-1, groups+1 done
  int m_fidx [2];
  int m_midx [2];
  int m_cnt  [2];
  bit m_rq   [2];
  bit m_rd   [2];
  bit m_fail [2];
  bit m_mis  [2];
  bit m_seq  [2];
  bit m_ovl  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_orig[d] = 0; m_dup[d] = 0; m_t[d] = 0; m_fidx[d] = -1; m_midx[d] = 0;
      m_cnt[d] = 0; m_rq[d] = 0; m_rd[d] = 0; m_fail[d] = 0; m_mis[d] = 0;
      m_seq[d] = 0; m_ovl[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int mx, no, nd, fi, t0;
    bit trig, seqset, nrq, latch, misset, cinc;
    mx = cmax(d);
    t0 = m_t[d];
    trig = chk_en && m_rq[d] && !m_rd[d];
    no = m_orig[d] + ((orig_commit && m_orig[d] < mx) ? 1 : 0);
    nd = m_dup[d]  + ((dup_commit  && m_dup[d]  < mx) ? 1 : 0);
    seqset = (orig_commit || dup_commit) && (no == mx || nd == mx || nd > no);
    nrq = (m_orig[d] == m_dup[d]) && m_orig[d] != 0 && m_orig[d] != mx && m_dup[d] != mx;
    latch = 0; misset = 0; cinc = 0;
    if (t0 == 0) begin
      if (trig) begin
        fi = -1;
        for (int p = 0; p < NR; p++)
          if (fi < 0 && !(p == 0 && skip0(d) == 1) && regs[p] != regs[p+NR]) fi = p;
        m_fidx[d] = fi;
        m_fail[d] = (fi >= 0);
        m_t[d] = 1;
      end
    end else if (t0 <= groups(d)) begin
      if (m_fidx[d] >= 0 && (m_fidx[d] / lanes(d)) == t0 - 1 && !m_mis[d]) latch = 1;
      m_t[d] = t0 + 1;
    end else begin
      misset = m_fail[d];
      cinc = 1;
      m_t[d] = 0;
    end
    m_orig[d] = no;
    m_dup[d]  = nd;
    m_rd[d]   = m_rq[d];
    m_rq[d]   = nrq;
    m_seq[d]  = seqset || (m_seq[d] && !clr_err);
    m_ovl[d]  = (trig && t0 != 0) || (m_ovl[d] && !clr_err);
    m_mis[d]  = misset || (m_mis[d] && !clr_err);
    if (latch)        m_midx[d] = m_fidx[d];
    else if (clr_err) m_midx[d] = 0;
    if (cinc && m_cnt[d] < mx) m_cnt[d] = m_cnt[d] + 1;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic busy, input logic done, input logic pass,
                         input logic mis, input int midx, input logic seq, input logic ovl,
                         input int cnt);
    string s;
    bit e_done;
    s = (d == 0) ? "a" : "b";
    e_done = (m_t[d] == groups(d) + 1);
    chk({s, "_busy"},         busy, m_t[d] != 0);
    chk({s, "_check_done"},   done, e_done);
    chk({s, "_check_pass"},   pass, e_done && !m_fail[d]);
    chk({s, "_mismatch"},     mis,  m_mis[d]);
    chk({s, "_mismatch_idx"}, midx, m_midx[d]);
    chk({s, "_seq_err"},      seq,  m_seq[d]);
    chk({s, "_overlap_err"},  ovl,  m_ovl[d]);
    chk({s, "_check_count"},  cnt,  m_cnt[d]);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, a_busy, a_done, a_pass, a_mis, int'(a_midx), a_seq, a_ovl, int'(a_cnt));
    cmp_dut(1, b_busy, b_done, b_pass, b_mis, int'(b_midx), b_seq, b_ovl, int'(b_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    orig_commit = 0; dup_commit = 0; clr_err = 0;
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic commit(input bit o, input bit d);
    orig_commit = o; dup_commit = d;
    @(negedge clk);
    orig_commit = 0; dup_commit = 0;
  endtask

  task automatic set_regs_equal();
    logic [XL-1:0] v;
    for (int i = 0; i < NR; i++) begin
      v = $urandom;
      regs[i] = v;
      regs[i+NR] = v;
    end
  endtask

  task automatic commits_3_3();
    repeat (3) commit(1, 0);
    repeat (3) commit(0, 1);
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (!a_done && n < 60) begin @(negedge clk); n++; end
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    while (!b_done && n < 60) begin @(negedge clk); n++; end
  endtask

  task automatic wait_busy_a();
    int n;
    n = 0;
    while (!a_busy && n < 20) begin @(negedge clk); n++; end
    chk("wait_busy_in_time", n < 20, 1);
  endtask

  task automatic count_done_a(input int cycles, output int k);
    k = 0;
    repeat (cycles) begin @(negedge clk); if (a_done) k++; end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, k;
    rst = 1'b0; chk_en = 1'b0; clr_err = 1'b0; orig_commit = 1'b0; dup_commit = 1'b0;
    for (int i = 0; i < 2*NR; i++) regs[i] = '0;
    @(negedge clk);
    chk("reset_busy", a_busy, 0);
    chk("reset_check_count", a_cnt, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // 1: clean check, latency 6 edges after the last dup commit (5 after trig)
    do_reset(); set_regs_equal(); commits_3_3();
    wait_done_a(n);
    chk("t1_latency", n, 6);
    chk("t1_pass", a_pass, 1);
    @(negedge clk);
    chk("t1_count", a_cnt, 1);

    // 2: pair 5 differs
    do_reset(); set_regs_equal(); regs[5] = 32'h1234; regs[21] = 32'h1235; commits_3_3();
    wait_done_a(n);
    chk("t2_pass", a_pass, 0);
    @(negedge clk);
    chk("t2_mismatch", a_mis, 1);
    chk("t2_mismatch_idx", a_midx, 5);

    // 3: pair 0 differs; skipped on dut_a, reported on dut_b
    do_reset(); set_regs_equal(); regs[0] = 32'hDEAD; regs[16] = 32'h0; commits_3_3();
    wait_done_a(n);
    chk("t3_a_pass", a_pass, 1);
    wait_done_b(n);
    chk("t3_b_done_in_time", n < 60, 1);
    chk("t3_b_pass", b_pass, 0);
    @(negedge clk);
    chk("t3_b_mismatch_idx", b_midx, 0);
    chk("t3_b_mismatch", b_mis, 1);

    // 4: dup before orig
    do_reset(); set_regs_equal(); commit(0, 1);
    chk("t4_seq_set", a_seq, 1);
    count_done_a(10, k);
    chk("t4_no_check", k, 0);
    chk("t4_count", a_cnt, 0);
    clr_err = 1; @(negedge clk); clr_err = 0;
    chk("t4_seq_cleared", a_seq, 0);

    // 5: second trigger while scanning
    do_reset(); set_regs_equal(); commits_3_3();
    wait_busy_a();
    commit(1, 0); commit(0, 1);
    count_done_a(20, k);
    chk("t5_one_done", k, 1);
    chk("t5_overlap", a_ovl, 1);
    chk("t5_count", a_cnt, 1);

    // 6: reset mid-scan
    do_reset(); set_regs_equal(); commits_3_3();
    wait_busy_a();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_busy_now", a_busy, 0);
    chk("t6_done_now", a_done, 0);
    chk("t6_count_now", a_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    count_done_a(15, k);
    chk("t6_no_done_after", k, 0);
    commits_3_3();
    wait_done_a(n);
    chk("t6_latency", n, 6);
    chk("t6_pass", a_pass, 1);
    @(negedge clk);
    chk("t6_count", a_cnt, 1);

    // 7: counter saturation on the narrow instance
    do_reset();
    repeat (15) commit(1, 0);
    chk("t7_b_seq_sat", b_seq, 1);
    chk("t7_a_seq", a_seq, 0);

    // random phase
    do_reset(); set_regs_equal();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        orig_commit = ($urandom_range(99) < 40);
        dup_commit  = ($urandom_range(99) < 40);
        chk_en      = ($urandom_range(9) != 0);
        clr_err     = (m_t[0] == 0 && m_t[1] == 0 && $urandom_range(29) == 0);
        if ($urandom_range(9) < 3) begin
          set_regs_equal();
          if ($urandom_range(1) == 0) begin
            k = $urandom_range(NR-1);
            regs[k+NR] = regs[k+NR] ^ (32'h1 << $urandom_range(31));
          end
        end
        @(negedge clk);
      end
    end
    orig_commit = 0; dup_commit = 0; clr_err = 0;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
